// File: rtl/matrix_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_buffer
// Purpose  : Captures the matrix ALU write stream into a private register
//            array, tracks written cells, then streams the matrix out in
//            raster order over a valid/ready handshake.
// Option   : RESULT_BUF_CHECKSUM_EN adds a running sum of streamed elements.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_result_buffer #(
  parameter int MAX_ROWS = 5,
  parameter int MAX_COLS = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_start_i,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_row_i,
  input  logic [3:0]        wr_col_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              alu_done_i,
  input  logic              out_start_i,
  input  logic [3:0]        out_rows_i,
  input  logic [3:0]        out_cols_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [3:0]        out_row_o,
  output logic [3:0]        out_col_o,
  output logic              out_last_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic              err_oob_o,
  output logic              err_dim_o,
  output logic [DATA_W-1:0] out_checksum_o
);

  localparam int         c_CELLS  = MAX_ROWS * MAX_COLS;
  localparam int         c_ADDR_W = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;
  localparam logic [3:0] c_ROWS   = 4'(MAX_ROWS);
  localparam logic [3:0] c_COLS   = 4'(MAX_COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_STREAM  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [c_CELLS-1:0] map_q;
  logic [DATA_W-1:0] mem_q [c_CELLS];
  logic              result_valid_q, err_oob_q, err_dim_q;
  logic [3:0]        rows_q, cols_q, rd_row_q, rd_col_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;

  logic              w_idle_hold, w_hs, w_wr_ok, w_dim_ok;
  logic              w_cap_clr, w_wr, w_oob, w_done, w_accept, w_dim_bad;
  logic [3:0]        w_nxt_row, w_nxt_col, w_ld_row, w_ld_col, w_rows_sel, w_cols_sel;
  logic              w_ld_last;
  logic [c_ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Control decode: cap_start wins over everything else outside STREAM.
  always_comb begin
    w_idle_hold = (state_q == S_IDLE) || (state_q == S_HOLD);
    w_hs        = out_valid_q && out_ready_i;
    w_wr_ok     = (wr_row_i < c_ROWS) && (wr_col_i < c_COLS);
    w_dim_ok    = (out_rows_i != 4'd0) && (out_cols_i != 4'd0) &&
                  (out_rows_i <= c_ROWS) && (out_cols_i <= c_COLS) && result_valid_q;
    w_cap_clr   = cap_start_i && (state_q != S_STREAM);
    w_wr        = (state_q == S_CAPTURE) && !cap_start_i && wr_en_i && w_wr_ok;
    w_oob       = (state_q == S_CAPTURE) && !cap_start_i && wr_en_i && !w_wr_ok;
    w_done      = (state_q == S_CAPTURE) && !cap_start_i && alu_done_i;
    w_accept    = w_idle_hold && !cap_start_i && out_start_i && w_dim_ok;
    w_dim_bad   = w_idle_hold && !cap_start_i && out_start_i && !w_dim_ok;
    w_wr_addr   = c_ADDR_W'(wr_row_i) * c_ADDR_W'(MAX_COLS) + c_ADDR_W'(wr_col_i);
  end

  // Raster index walk and the element to load for the next beat.
  always_comb begin
    if (rd_col_q == cols_q - 4'd1) begin
      w_nxt_col = 4'd0;
      w_nxt_row = rd_row_q + 4'd1;
    end else begin
      w_nxt_col = rd_col_q + 4'd1;
      w_nxt_row = rd_row_q;
    end
    w_ld_row   = w_accept ? 4'd0 : w_nxt_row;
    w_ld_col   = w_accept ? 4'd0 : w_nxt_col;
    w_rows_sel = w_accept ? out_rows_i : rows_q;
    w_cols_sel = w_accept ? out_cols_i : cols_q;
    w_ld_last  = (w_ld_row == w_rows_sel - 4'd1) && (w_ld_col == w_cols_sel - 4'd1);
    w_rd_addr  = c_ADDR_W'(w_ld_row) * c_ADDR_W'(MAX_COLS) + c_ADDR_W'(w_ld_col);
    w_rd_data  = map_q[w_rd_addr] ? mem_q[w_rd_addr] : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (cap_start_i)   state_d = S_CAPTURE;
        else if (w_accept) state_d = S_STREAM;
      end
      S_CAPTURE: begin
        if (!cap_start_i && alu_done_i) state_d = S_HOLD;
      end
      S_STREAM: begin
        if (w_hs && out_last_q) state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy_o         = (state_q == S_CAPTURE) || (state_q == S_STREAM);
    out_valid_o    = out_valid_q;
    out_data_o     = out_data_q;
    out_row_o      = rd_row_q;
    out_col_o      = rd_col_q;
    out_last_o     = out_last_q;
    result_valid_o = result_valid_q;
    err_oob_o      = err_oob_q;
    err_dim_o      = err_dim_q;
  end

  // Element storage; unwritten cells are masked by the map, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[w_wr_addr] <= wr_data_i;
  end

  // Capture bookkeeping: written-map, sticky out-of-range flag, result flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q          <= '0;
      err_oob_q      <= 1'b0;
      result_valid_q <= 1'b0;
      err_dim_q      <= 1'b0;
    end else begin
      err_dim_q <= w_dim_bad;
      if (w_cap_clr) begin
        map_q          <= '0;
        err_oob_q      <= 1'b0;
        result_valid_q <= 1'b0;
      end
      if (w_wr)   map_q[w_wr_addr] <= 1'b1;
      if (w_oob)  err_oob_q        <= 1'b1;
      if (w_done) result_valid_q   <= 1'b1;
    end
  end

  // Streaming registers: load on accept, advance on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= 4'd0;
      cols_q      <= 4'd0;
      rd_row_q    <= 4'd0;
      rd_col_q    <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (w_accept) begin
      rows_q      <= out_rows_i;
      cols_q      <= out_cols_i;
      rd_row_q    <= 4'd0;
      rd_col_q    <= 4'd0;
      out_valid_q <= 1'b1;
      out_last_q  <= w_ld_last;
      out_data_q  <= w_rd_data;
    end else if ((state_q == S_STREAM) && w_hs) begin
      if (out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        rd_row_q    <= w_nxt_row;
        rd_col_q    <= w_nxt_col;
        out_last_q  <= w_ld_last;
        out_data_q  <= w_rd_data;
      end
    end
  end

`ifdef RESULT_BUF_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  // Running modulo-2^DATA_W sum of handshaken elements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               chk_q <= '0;
    else if (w_accept)                        chk_q <= '0;
    else if ((state_q == S_STREAM) && w_hs)   chk_q <= chk_q + out_data_q;
  end

  assign out_checksum_o = chk_q;
`else
  assign out_checksum_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_result_buffer
// Purpose  : Directed self-checking bench for matrix_result_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_result_buffer;

`ifdef RESULT_BUF_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_start = 1'b0, wr_en = 1'b0, alu_done = 1'b0, out_start = 1'b0;
  logic [3:0]  wr_row = '0, wr_col = '0, out_rows = '0, out_cols = '0;
  logic [31:0] wr_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, result_valid, busy, err_oob, err_dim;
  logic [31:0] out_data, out_checksum;
  logic [3:0]  out_row, out_col;

  int checks = 0;
  int errors = 0;

  matrix_result_buffer #(.MAX_ROWS(5), .MAX_COLS(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cap_start_i(cap_start), .wr_en_i(wr_en), .wr_row_i(wr_row), .wr_col_i(wr_col),
    .wr_data_i(wr_data), .alu_done_i(alu_done), .out_start_i(out_start),
    .out_rows_i(out_rows), .out_cols_i(out_cols), .out_ready_i(out_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_row_o(out_row),
    .out_col_o(out_col), .out_last_o(out_last), .result_valid_o(result_valid),
    .busy_o(busy), .err_oob_o(err_oob), .err_dim_o(err_dim),
    .out_checksum_o(out_checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_begin();
    cap_start = 1'b1; tick(); cap_start = 1'b0;
  endtask

  task automatic write_cell(input logic [3:0] r, input logic [3:0] c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic finish_capture();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
  endtask

  task automatic start_stream(input logic [3:0] r, input logic [3:0] c);
    out_start = 1'b1; out_rows = r; out_cols = c; tick(); out_start = 1'b0;
  endtask

  // Checks the beat currently presented, then clocks once (handshake if ready).
  task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] r,
                      input logic [3:0] c, input logic last);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".data"},  out_data, d);
    check({tag, ".row"},   {28'd0, out_row}, {28'd0, r});
    check({tag, ".col"},   {28'd0, out_col}, {28'd0, c});
    check({tag, ".last"},  {31'd0, out_last}, {31'd0, last});
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.valid",  {31'd0, out_valid}, 32'd0);
    check("rst.busy",   {31'd0, busy}, 32'd0);
    check("rst.rvalid", {31'd0, result_valid}, 32'd0);
    check("rst.oob",    {31'd0, err_oob}, 32'd0);
    check("rst.dim",    {31'd0, err_dim}, 32'd0);
    check("rst.data",   out_data, 32'd0);
    check("rst.chk",    out_checksum, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 2x3 capture and stream, ready held high
    capture_begin();
    check("t1.busy_cap", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        write_cell(4'(i), 4'(j), 32'(10 * i + j));
    finish_capture();
    check("t1.rvalid", {31'd0, result_valid}, 32'd1);
    check("t1.busy_hold", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    start_stream(4'd2, 4'd3);
    check("t1.busy_str", {31'd0, busy}, 32'd1);
    beat("t1.b0", 32'd0,  4'd0, 4'd0, 1'b0);
    beat("t1.b1", 32'd1,  4'd0, 4'd1, 1'b0);
    beat("t1.b2", 32'd2,  4'd0, 4'd2, 1'b0);
    beat("t1.b3", 32'd10, 4'd1, 4'd0, 1'b0);
    beat("t1.b4", 32'd11, 4'd1, 4'd1, 1'b0);
    beat("t1.b5", 32'd12, 4'd1, 4'd2, 1'b1);
    check("t1.valid_end", {31'd0, out_valid}, 32'd0);
    check("t1.last_end",  {31'd0, out_last}, 32'd0);
    check("t1.busy_end",  {31'd0, busy}, 32'd0);
    check("t1.rvalid_end", {31'd0, result_valid}, 32'd1);
    check("t1.chk", out_checksum, CHK_EN ? 32'd36 : 32'd0);

    // 2x2 with backpressure: ready low two cycles before every handshake
    capture_begin();
    write_cell(4'd0, 4'd0, 32'hA0);
    write_cell(4'd0, 4'd1, 32'hA1);
    write_cell(4'd1, 4'd0, 32'hB0);
    write_cell(4'd1, 4'd1, 32'hB1);
    finish_capture();
    out_ready = 1'b0;
    start_stream(4'd2, 4'd2);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_d;
      exp_d = (k < 2) ? (32'hA0 + 32'(k)) : (32'hB0 + 32'(k - 2));
      out_ready = 1'b0;
      check("t2.hold_data0", out_data, exp_d);
      tick();
      check("t2.hold_valid", {31'd0, out_valid}, 32'd1);
      check("t2.hold_data1", out_data, exp_d);
      tick();
      out_ready = 1'b1;
      beat("t2.beat", exp_d, 4'(k / 2), 4'(k % 2), k == 3);
    end
    check("t2.valid_end", {31'd0, out_valid}, 32'd0);

    // Partial write plus an out-of-range write
    capture_begin();
    check("t3.map_clr_oob", {31'd0, err_oob}, 32'd0);
    write_cell(4'd0, 4'd0, 32'd7);
    write_cell(4'd5, 4'd0, 32'd99);
    check("t3.oob", {31'd0, err_oob}, 32'd1);
    finish_capture();
    check("t3.oob_sticky", {31'd0, err_oob}, 32'd1);
    start_stream(4'd2, 4'd2);
    beat("t3.b0", 32'd7, 4'd0, 4'd0, 1'b0);
    beat("t3.b1", 32'd0, 4'd0, 4'd1, 1'b0);
    beat("t3.b2", 32'd0, 4'd1, 4'd0, 1'b0);
    beat("t3.b3", 32'd0, 4'd1, 4'd1, 1'b1);

    // Bad readout dims in HOLD
    start_stream(4'd0, 4'd2);
    check("t4.dim_r0", {31'd0, err_dim}, 32'd1);
    check("t4.valid_r0", {31'd0, out_valid}, 32'd0);
    check("t4.busy_r0", {31'd0, busy}, 32'd0);
    tick();
    check("t4.dim_pulse", {31'd0, err_dim}, 32'd0);
    start_stream(4'd2, 4'd6);
    check("t4.dim_c6", {31'd0, err_dim}, 32'd1);
    check("t4.valid_c6", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4.dim_pulse2", {31'd0, err_dim}, 32'd0);
    check("t4.busy_c6", {31'd0, busy}, 32'd0);

    // Write in the same cycle as alu_done
    capture_begin();
    wr_en = 1'b1; wr_row = 4'd1; wr_col = 4'd1; wr_data = 32'hFFFFFFFD; alu_done = 1'b1;
    tick();
    wr_en = 1'b0; alu_done = 1'b0;
    check("t5.rvalid", {31'd0, result_valid}, 32'd1);
    check("t5.oob_clr", {31'd0, err_oob}, 32'd0);
    start_stream(4'd2, 4'd2);
    beat("t5.b0", 32'd0, 4'd0, 4'd0, 1'b0);
    beat("t5.b1", 32'd0, 4'd0, 4'd1, 1'b0);
    beat("t5.b2", 32'd0, 4'd1, 4'd0, 1'b0);
    beat("t5.b3", 32'hFFFFFFFD, 4'd1, 4'd1, 1'b1);

    // Checksum over {1,2,3,0xFFFFFFFF}, streamed twice
    capture_begin();
    write_cell(4'd0, 4'd0, 32'd1);
    write_cell(4'd0, 4'd1, 32'd2);
    write_cell(4'd1, 4'd0, 32'd3);
    write_cell(4'd1, 4'd1, 32'hFFFFFFFF);
    finish_capture();
    for (int p = 0; p < 2; p++) begin
      start_stream(4'd2, 4'd2);
      beat("t6.b0", 32'd1, 4'd0, 4'd0, 1'b0);
      beat("t6.b1", 32'd2, 4'd0, 4'd1, 1'b0);
      beat("t6.b2", 32'd3, 4'd1, 4'd0, 1'b0);
      beat("t6.b3", 32'hFFFFFFFF, 4'd1, 4'd1, 1'b1);
      check("t6.chk", out_checksum, CHK_EN ? 32'd5 : 32'd0);
      tick();
      check("t6.chk_hold", out_checksum, CHK_EN ? 32'd5 : 32'd0);
    end

    // Asynchronous reset during the second beat
    start_stream(4'd2, 4'd2);
    beat("t7.b0", 32'd1, 4'd0, 4'd0, 1'b0);
    check("t7.valid_b1", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7.rst_valid", {31'd0, out_valid}, 32'd0);
    check("t7.rst_busy",  {31'd0, busy}, 32'd0);
    check("t7.rst_rvalid", {31'd0, result_valid}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    start_stream(4'd2, 4'd2);
    check("t7.idle_dim", {31'd0, err_dim}, 32'd1);
    check("t7.idle_valid", {31'd0, out_valid}, 32'd0);
    check("t7.idle_busy", {31'd0, busy}, 32'd0);

    // Map cleared by reset: capture without writes streams zeros
    capture_begin();
    finish_capture();
    start_stream(4'd1, 4'd1);
    beat("t8.b0", 32'd0, 4'd0, 4'd0, 1'b1);
    check("t8.valid_end", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
